shuffle_sched: RTL

SHUFFLE_SCHED -- requirements
Module: shuffle_sched

---
 rtl/shuffle_sched.sv | 128 ++++++++++++
 1 files changed

// File: rtl/shuffle_sched.sv
// Two-requester round-robin job scheduler: the granted job's operand bytes are
// pushed through a short programmable byte/nibble shuffle, then handed back.
module shuffle_sched #(
  parameter int unsigned PROG_LEN = 4,
  parameter int unsigned RR_INIT  = 0
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic [1:0]  req,
  input  logic [7:0]  a_in0,
  input  logic [7:0]  b_in0,
  input  logic [7:0]  a_in1,
  input  logic [7:0]  b_in1,
  output logic [1:0]  gnt,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [1:0]  cfg_op,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_src
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_prio;
  logic [2:0]  r_step;
  logic [15:0] r_shreg;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic        r_src;
  logic [1:0]  r_prog [8];

  logic        w_grant;
  logic        w_win;
  logic [7:0]  w_a_sel;
  logic [7:0]  w_b_sel;
  logic [1:0]  w_op;
  logic        w_last;
  logic [15:0] w_shreg_nxt;

  // Priority only matters when both request; a lone requester always wins.
  always_comb begin
    w_grant = (r_state == S_IDLE) && (req != 2'b00);
    w_win   = (req == 2'b11) ? r_prio : req[1];
    w_a_sel = w_win ? a_in1 : a_in0;
    w_b_sel = w_win ? b_in1 : b_in0;
  end

  always_comb begin
    w_op   = r_prog[r_step];
    w_last = (r_step == 3'(PROG_LEN - 1));
    unique case (w_op)
      2'd0:    w_shreg_nxt = {r_shreg[7:0], r_shreg[15:8]};
      2'd1:    w_shreg_nxt = {r_shreg[7:0], r_a};
      2'd2:    w_shreg_nxt = {r_b, r_shreg[15:8]};
      default: w_shreg_nxt = {r_shreg[3:0], r_shreg[7:4], r_shreg[11:8], r_shreg[15:12]};
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= S_IDLE;
      r_prio  <= 1'(RR_INIT);
      r_step  <= '0;
      r_shreg <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_src   <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) r_prog[i] <= 2'(i);
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          // Program writes land at this edge, before the new job's first op reads them.
          if (cfg_we) r_prog[cfg_addr] <= cfg_op;
          if (w_grant) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_shreg <= {w_a_sel, w_b_sel};
            r_step  <= '0;
            r_src   <= w_win;
            r_prio  <= ~w_win;
          end
        end
        S_RUN: begin
          r_shreg <= w_shreg_nxt;
          if (!w_last) r_step <= r_step + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    gnt       = '0;
    busy      = 1'b1;
    res_valid = 1'b0;
    res_data  = '0;
    res_src   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_grant) begin
          w_next = S_RUN;
          gnt    = w_win ? 2'b10 : 2'b01;
        end
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        res_data  = r_shreg;
        res_src   = r_src;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Grant is combinational from req, so it must be masked while reset is held.
    if (!nReset) gnt = '0;
  end

endmodule
